// File: rtl/ysyx_23060061_axi_pkg.sv
// Shared types and AXI4 encodings for the N-master AXI arbiter.
package ysyx_23060061_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060061_axi_arbiter_n_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr_i when RR_EN, else lowest index wins.
module ysyx_23060061_rr_arbiter #(
  parameter int N     = 2,
  parameter bit RR_EN = 1'b0,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  int   start;
  logic found;

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    start = RR_EN ? int'(ptr_i) : 0;
    // Walk priority slots in order start, start+1, ... wrapping at N.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req_i[j] && ((start + i == j) || (start + i == j + N))) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_23060061_axi_arbiter_n.sv
// N-master to 1-slave AXI4 arbiter with independent read/write paths and burst-held grants.
// Define YSYX_23060061_ARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module ysyx_23060061_axi_arbiter_n
  import ysyx_23060061_axi_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          s_arvalid,
  output logic [NUM_M-1:0]          s_arready,
  input  logic [NUM_M*ADDR_W-1:0]   s_araddr,
  input  logic [NUM_M*ID_W-1:0]     s_arid,
  input  logic [NUM_M*8-1:0]        s_arlen,
  input  logic [NUM_M*3-1:0]        s_arsize,
  input  logic [NUM_M*2-1:0]        s_arburst,
  output logic [NUM_M-1:0]          s_rvalid,
  input  logic [NUM_M-1:0]          s_rready,
  output logic [NUM_M-1:0]          s_rlast,
  output logic [NUM_M*DATA_W-1:0]   s_rdata,
  output logic [NUM_M*2-1:0]        s_rresp,
  output logic [NUM_M*ID_W-1:0]     s_rid,
  input  logic [NUM_M-1:0]          s_awvalid,
  output logic [NUM_M-1:0]          s_awready,
  input  logic [NUM_M*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_M*ID_W-1:0]     s_awid,
  input  logic [NUM_M*8-1:0]        s_awlen,
  input  logic [NUM_M*3-1:0]        s_awsize,
  input  logic [NUM_M*2-1:0]        s_awburst,
  input  logic [NUM_M-1:0]          s_wvalid,
  output logic [NUM_M-1:0]          s_wready,
  input  logic [NUM_M-1:0]          s_wlast,
  input  logic [NUM_M*DATA_W-1:0]   s_wdata,
  input  logic [NUM_M*DATA_W/8-1:0] s_wstrb,
  output logic [NUM_M-1:0]          s_bvalid,
  input  logic [NUM_M-1:0]          s_bready,
  output logic [NUM_M*2-1:0]        s_bresp,
  output logic [NUM_M*ID_W-1:0]     s_bid,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [ID_W-1:0]           m_arid,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic                      m_rlast,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic [ID_W-1:0]           m_rid,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic [ID_W-1:0]           m_awid,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic                      m_wlast,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  input  logic [ID_W-1:0]           m_bid
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  rd_state_e        rd_state_q, rd_state_d;
  wr_state_e        wr_state_q, wr_state_d;
  logic [NUM_M-1:0] rgnt_q, rgnt_d, wgnt_q, wgnt_d, rgnt_arb, wgnt_arb;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
  logic [PTR_W-1:0] rptr, wptr;

`ifdef YSYX_23060061_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_M-1:0] gnt);
    logic [PTR_W-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_M; k++)
      if (gnt[k]) p = (k == NUM_M - 1) ? '0 : PTR_W'(k + 1);
    return p;
  endfunction

  // Pointers only move when a new grant is actually taken from IDLE.
  assign rptr_d = (rd_state_q == R_IDLE && |s_arvalid) ? next_ptr(rgnt_arb) : rptr_q;
  assign wptr_d = (wr_state_q == W_IDLE && |s_awvalid) ? next_ptr(wgnt_arb) : wptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end
  assign rptr = rptr_q;
  assign wptr = wptr_q;
`else
  localparam bit RR_EN = 1'b0;
  assign rptr = '0;
  assign wptr = '0;
`endif

  ysyx_23060061_rr_arbiter #(.N(NUM_M), .RR_EN(RR_EN), .PTR_W(PTR_W)) u_rd_arb (
    .req_i(s_arvalid), .ptr_i(rptr), .gnt_o(rgnt_arb)
  );
  ysyx_23060061_rr_arbiter #(.N(NUM_M), .RR_EN(RR_EN), .PTR_W(PTR_W)) u_wr_arb (
    .req_i(s_awvalid), .ptr_i(wptr), .gnt_o(wgnt_arb)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rgnt_q     <= '0;
      wgnt_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rgnt_q     <= rgnt_d;
      wgnt_q     <= wgnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    rgnt_d      = rgnt_q;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_araddr    = '0;
    m_arid      = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arburst   = '0;
    sel_arvalid = 1'b0;
    sel_rready  = 1'b0;
    s_arready   = '0;
    s_rvalid    = '0;
    s_rlast     = '0;
    s_rdata     = '0;
    s_rresp     = '0;
    s_rid       = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (rgnt_q[i]) begin
        m_araddr    = s_araddr[i*ADDR_W +: ADDR_W];
        m_arid      = s_arid[i*ID_W +: ID_W];
        m_arlen     = s_arlen[i*8 +: 8];
        m_arsize    = s_arsize[i*3 +: 3];
        m_arburst   = s_arburst[i*2 +: 2];
        sel_arvalid = s_arvalid[i];
        sel_rready  = s_rready[i];
      end
    end
    case (rd_state_q)
      R_IDLE: begin
        if (|s_arvalid) begin
          rgnt_d     = rgnt_arb;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = sel_arvalid;
        s_arready = rgnt_q & {NUM_M{m_arready}};
        if (m_arvalid && m_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_rready = sel_rready;
        for (int i = 0; i < NUM_M; i++) begin
          if (rgnt_q[i]) begin
            s_rvalid[i]                  = m_rvalid;
            s_rlast[i]                   = m_rlast;
            s_rdata[i*DATA_W +: DATA_W]  = m_rdata;
            s_rresp[i*2 +: 2]            = m_rresp;
            s_rid[i*ID_W +: ID_W]        = m_rid;
          end
        end
        // Error responses do not end the burst; only rlast does.
        if (m_rvalid && m_rready && m_rlast) begin
          rd_state_d = R_IDLE;
          rgnt_d     = '0;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    wgnt_d      = wgnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    m_awaddr    = '0;
    m_awid      = '0;
    m_awlen     = '0;
    m_awsize    = '0;
    m_awburst   = '0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    s_awready   = '0;
    s_wready    = '0;
    s_bvalid    = '0;
    s_bresp     = '0;
    s_bid       = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (wgnt_q[i]) begin
        m_awaddr    = s_awaddr[i*ADDR_W +: ADDR_W];
        m_awid      = s_awid[i*ID_W +: ID_W];
        m_awlen     = s_awlen[i*8 +: 8];
        m_awsize    = s_awsize[i*3 +: 3];
        m_awburst   = s_awburst[i*2 +: 2];
        m_wdata     = s_wdata[i*DATA_W +: DATA_W];
        m_wstrb     = s_wstrb[i*STRB_W +: STRB_W];
        m_wlast     = s_wlast[i];
        sel_awvalid = s_awvalid[i];
        sel_wvalid  = s_wvalid[i];
        sel_bready  = s_bready[i];
      end
    end
    case (wr_state_q)
      W_IDLE: begin
        if (|s_awvalid) begin
          wgnt_d     = wgnt_arb;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_XFER;
        end
      end
      W_XFER: begin
        // AW and W run concurrently; each channel is masked once its sticky flag is set.
        m_awvalid = sel_awvalid & ~aw_done_q;
        m_wvalid  = sel_wvalid & ~w_done_q;
        s_awready = wgnt_q & {NUM_M{m_awready & ~aw_done_q}};
        s_wready  = wgnt_q & {NUM_M{m_wready & ~w_done_q}};
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (m_wvalid && m_wready && m_wlast) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        m_bready = sel_bready;
        for (int i = 0; i < NUM_M; i++) begin
          if (wgnt_q[i]) begin
            s_bvalid[i]           = m_bvalid;
            s_bresp[i*2 +: 2]     = m_bresp;
            s_bid[i*ID_W +: ID_W] = m_bid;
          end
        end
        if (m_bvalid && m_bready) begin
          wr_state_d = W_IDLE;
          wgnt_d     = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

endmodule

// File: doc/ysyx_23060061_axi_arbiter_n.md
# ysyx_23060061_axi_arbiter_n

Parametrised N-master to 1-slave AXI4 arbiter that replaces the fixed two-port (IFU/LSU) bus arbiter in front of `io_master_*`. Read and write paths are arbitrated independently, so one master's load can proceed while another master's store is in flight. The arbiter supports full bursts (grant held until `rlast` or `b` handshake) and round-robin fairness. It sits between core-side AXI masters (IFU, LSU, future DMA/cache refill) and the SoC master port.

## Interface
Parameters:
- `NUM_M`, 2, number of upstream masters (1..8); index 0 = IFU, 1 = LSU
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width; strobe width `DATA_W/8`
- `ID_W`, 4, AXI ID width

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-low
- `s_ar{valid,ready}`, `s_aw{valid,ready}`, `s_w{valid,ready,last}`, `s_r{valid,ready,last}`, `s_b{valid,ready}`  in/out  NUM_M  per-master handshake bits; `*valid`/`*ready` drive direction per AXI4
- `s_araddr`, `s_awaddr`  in  NUM_M*ADDR_W  flattened master addresses
- `s_arid`, `s_awid`  in  NUM_M*ID_W;  `s_rid`, `s_bid`  out  NUM_M*ID_W
- `s_arlen`, `s_awlen`  in  NUM_M*8;  `s_arsize`, `s_awsize`  in  NUM_M*3;  `s_arburst`, `s_awburst`  in  NUM_M*2
- `s_wdata`  in  NUM_M*DATA_W;  `s_wstrb`  in  NUM_M*DATA_W/8;  `s_rdata`  out  NUM_M*DATA_W
- `s_rresp`, `s_bresp`  out  NUM_M*2
- `m_*`  mirrored single AXI4 master port (same fields, widths ADDR_W/DATA_W/ID_W), direction reversed

## Operation
- Read FSM `R_IDLE -> R_ADDR -> R_DATA -> R_IDLE`:
  - R_IDLE: if any `s_arvalid`, register one-hot `rgnt` from the arbiter and go to R_ADDR.
  - R_ADDR: mux granted AR fields to `m_ar*`; on `m_arvalid & m_arready`, go to R_DATA.
  - R_DATA: route `m_r*` to the granted master only; on `m_rvalid & m_rready & m_rlast`, go to R_IDLE.
- Write FSM `W_IDLE -> W_XFER -> W_RESP -> W_IDLE`:
  - W_IDLE: grant on any `s_awvalid`.
  - W_XFER: forward AW and W channels concurrently. Sticky flags `aw_done` and `w_done` (`w_done` set on the `wlast` handshake). Move to W_RESP when both are set, including when both are set in the same cycle.
  - W_RESP: route B to the granted master; on `m_bvalid & m_bready`, go to W_IDLE and clear the flags.
- Ungranted masters see every `*ready` = 0 and every `*valid` = 0. Their data/resp/id outputs are 0.
- `m_*valid` is 0 outside the owning state, and `m_rready`/`m_bready` are 0 outside R_DATA/W_RESP.
- `rresp`/`bresp` pass through unchanged. An error response does not abort the burst; the FSM still waits for `rlast`.
- A master's `s_wvalid` presented before its AW grant is held off (`s_wready` = 0).
- `NUM_M` = 1: arbitration is trivial, and the FSM behaviour is otherwise identical.

## Timing
- Reset (async assert, sync deassert by the caller): both FSMs IDLE, grants 0, flags 0, RR pointers 0. All `m_*valid`, `m_rready`, `m_bready` and `s_*` outputs are 0.
- Reset mid-burst: transaction abandoned, no completion to any master. Downstream recovery is the SoC's responsibility.
- Arbitration latency: request sampled in cycle t, `m_arvalid`/`m_awvalid` high in t+1.
- Data-path muxing is combinational on registered grant, so there is zero added latency per beat and full throughput of 1 beat/cycle.
- At least one IDLE cycle between consecutive transactions on the same path.
- Read and write paths are fully independent. Simultaneous read grant to master i and write grant to master j is legal, including i == j.

## Configuration
- `YSYX_23060061_ARB_RR_EN` defined: round-robin. After a grant to index k, priority order starts at k+1 (mod NUM_M). There are separate pointers for read and write, updated only on grant.
- Not defined: fixed priority, lowest index wins (IFU over LSU). Pointer registers are not generated.

## Structure
- Package `ysyx_23060061_axi_pkg`:
  - read/write FSM state enums
  - `AXI_BURST_INCR`, `AXI_RESP_OKAY`/`SLVERR`/`DECERR` constants
- Sub-module `ysyx_23060061_rr_arbiter` (params `N`, RR enable): inputs `req[N]` and pointer, output one-hot `gnt`. Combinational, instantiated once for read and once for write; pointer registers live in the parent.

## Test plan
- NUM_M=2, master 1 `araddr=0x8000_0100`, `arlen=3`, slave returns 4 beats `0x11..0x44` with `rlast` on the 4th -> master 1 receives exactly those 4 beats, and master 0 `s_rvalid` stays 0 throughout.
- Both masters assert `arvalid` in the same cycle, RR enabled, after reset -> order is 0, 1, 0, 1 over four back-to-back reads. With the macro undefined -> master 0 is always granted while it keeps requesting.
- Master 0 reads (`arlen=7`) while master 1 writes one beat `0xDEADBEEF`, `wstrb=0x0F` -> both complete with no interleaving stall, and the write reaches `m_wdata` unchanged.
- AW and `wlast` handshakes in the same cycle -> W_RESP entered the next cycle. W accepted 2 cycles before AW -> still completes with a single B to the owner.
- Slave returns `rresp=SLVERR` on beat 0 of a 2-beat read -> both beats are forwarded with resp intact, and the FSM returns to IDLE only after `rlast`.
- `rst` asserted during R_DATA beat 2 -> all valid/ready outputs 0 asynchronously. After release, a new read from master 1 is granted within 1 cycle.
